// File: rtl/sm_step_gen.sv
// Step/direction generator: runs a move of N+1-clock step periods with a
// programmable high time, a direction setup delay and a signed position count.
module sm_step_gen #(
  parameter int PER_W     = 17,
  parameter int PW_W      = 8,
  parameter int POS_W     = 32,
  parameter int DIR_SETUP = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_data_valid_trig,
  input  logic [PER_W-1:0] i_n,
  input  logic [PW_W-1:0]  i_pulse_width,
  input  logic             i_dir_in,
  input  logic             i_drv_enable_sm,
  input  logic             i_move_start,
  input  logic [POS_W-1:0] i_move_steps,
  input  logic             i_pos_clr,
  output logic             o_drv_step,
  output logic             o_drv_dir,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_aborted,
  output logic [POS_W-1:0] o_position,
  output logic [1:0]       o_dbg_state
);

  // Interface semantics: i_data_valid_trig and i_move_start are single-cycle
  // strobes sampled on the rising edge with no back-pressure; a move_start seen
  // while busy (o_busy=1) is dropped, there is no ready/acknowledge.

  // Wide enough for N+1 and pw_eff without overflow, plus a guard bit.
  localparam int CW = ((PER_W + 1 > PW_W) ? PER_W + 1 : PW_W) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_HIGH  = 2'd2,
    S_LOW   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [PER_W-1:0] r_sh_per;
  logic [PW_W-1:0]  r_sh_pw;
  logic             r_sh_dir;
  logic [PER_W-1:0] r_act_per;
  logic [PW_W-1:0]  r_act_pw;
  logic [POS_W-1:0] r_remaining;
  logic [POS_W-1:0] r_position;
  logic             r_abort_pend;
  logic             r_drv_step;
  logic             r_drv_dir;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;

  logic [CW-1:0]    w_period;
  logic [CW-1:0]    w_pw_ext;
  logic [CW-1:0]    w_low_len;
  logic             w_high_end;
  logic             w_low_end;
  logic             w_setup_end;
  state_t           w_load_state;
  logic             w_load;
  logic             w_pos_step;
  logic             w_done_set;
  logic             w_abort_set;

  // Active pw is stored already clamped to >= 1, so only the low time needs care.
  assign w_period     = CW'(r_act_per) + CW'(1);
  assign w_pw_ext     = CW'(r_act_pw);
  assign w_low_len    = (w_period > w_pw_ext) ? (w_period - w_pw_ext) : CW'(1);
  assign w_high_end   = (r_cnt == w_pw_ext - CW'(1));
  assign w_low_end    = (r_cnt == w_low_len - CW'(1));
  assign w_setup_end  = (r_cnt == CW'(DIR_SETUP - 1));
  assign w_load_state = (r_sh_dir != r_drv_dir) ? S_SETUP : S_HIGH;

  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_pos_step  = 1'b0;
    w_done_set  = 1'b0;
    w_abort_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_move_start && i_drv_enable_sm) begin
          if (i_move_steps == '0) begin
            w_done_set = 1'b1;
          end else begin
            w_load = 1'b1;
            w_next = w_load_state;
          end
        end
      end
      S_SETUP: begin
        if (!i_drv_enable_sm) begin
          w_next      = S_IDLE;
          w_abort_set = 1'b1;
        end else if (w_setup_end) begin
          w_next = S_HIGH;
        end
      end
      S_HIGH: begin
        // A started pulse always completes at full width, even when aborting.
        if (w_high_end) begin
          w_pos_step = 1'b1;
          if (r_abort_pend || !i_drv_enable_sm) begin
            w_next      = S_IDLE;
            w_abort_set = 1'b1;
          end else begin
            w_next = S_LOW;
          end
        end
      end
      S_LOW: begin
        if (!i_drv_enable_sm) begin
          w_next      = S_IDLE;
          w_abort_set = 1'b1;
        end else if (w_low_end) begin
          if (r_remaining == '0) begin
            w_next     = S_IDLE;
            w_done_set = 1'b1;
          end else begin
            w_load = 1'b1;
            w_next = w_load_state;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_sh_per     <= '0;
      r_sh_pw      <= PW_W'(1);
      r_sh_dir     <= 1'b0;
      r_act_per    <= '0;
      r_act_pw     <= PW_W'(1);
      r_remaining  <= '0;
      r_position   <= '0;
      r_abort_pend <= 1'b0;
      r_drv_step   <= 1'b0;
      r_drv_dir    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + CW'(1);

      if (i_data_valid_trig) begin
        r_sh_per <= i_n;
        r_sh_pw  <= (i_pulse_width == '0) ? PW_W'(1) : i_pulse_width;
        r_sh_dir <= i_dir_in;
      end

      // Shadow values reach the output timing only here, at a step boundary.
      if (w_load) begin
        r_act_per <= r_sh_per;
        r_act_pw  <= r_sh_pw;
        r_drv_dir <= r_sh_dir;
      end

      if (w_load && (r_state == S_IDLE)) begin
        r_remaining <= i_move_steps;
      end else if (w_pos_step) begin
        r_remaining <= r_remaining - POS_W'(1);
      end

      r_abort_pend <= (r_state == S_HIGH) && (w_next == S_HIGH) &&
                      (r_abort_pend || !i_drv_enable_sm);

      r_drv_step <= (w_next == S_HIGH);
      r_busy     <= (w_next != S_IDLE);
      r_done     <= w_done_set;
      r_aborted  <= w_abort_set;

      if (i_pos_clr) begin
        r_position <= '0;
      end else if (w_pos_step) begin
        r_position <= r_drv_dir ? (r_position + POS_W'(1)) : (r_position - POS_W'(1));
      end
    end
  end

  assign o_drv_step  = r_drv_step;
  assign o_drv_dir   = r_drv_dir;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_aborted   = r_aborted;
  assign o_position  = r_position;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sm_step_gen.sv
// Directed bench for sm_step_gen: each task runs one scenario, captures the
// per-cycle outputs after the start edge and compares against hand-derived timing.
module tb_sm_step_gen;

  localparam int PER_W = 17;
  localparam int PW_W  = 8;
  localparam int POS_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             trig;
  logic [PER_W-1:0] n_val;
  logic [PW_W-1:0]  pw_val;
  logic             dir_in;
  logic             en;
  logic             move_start;
  logic [POS_W-1:0] move_steps;
  logic             pos_clr;
  logic             drv_step;
  logic             drv_dir;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [POS_W-1:0] position;
  logic [1:0]       dbg_state;

  sm_step_gen #(.PER_W(PER_W), .PW_W(PW_W), .POS_W(POS_W), .DIR_SETUP(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_data_valid_trig(trig), .i_n(n_val),
    .i_pulse_width(pw_val), .i_dir_in(dir_in), .i_drv_enable_sm(en),
    .i_move_start(move_start), .i_move_steps(move_steps), .i_pos_clr(pos_clr),
    .o_drv_step(drv_step), .o_drv_dir(drv_dir), .o_busy(busy), .o_done(done),
    .o_aborted(aborted), .o_position(position), .o_dbg_state(dbg_state)
  );

  always #10 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic cap_step [0:63];
  logic cap_done [0:63];
  logic cap_busy [0:63];
  logic cap_abort[0:63];
  logic cap_dir  [0:63];
  int   num_p, done_cyc, done_cnt, abort_cyc, abort_cnt, busy_last;
  int   rise[0:7];
  int   hlen[0:7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_shadow(input int n, input int pw, input logic d);
    n_val  = PER_W'(n);
    pw_val = PW_W'(pw);
    dir_in = d;
    trig   = 1'b1;
    tick();
    trig   = 1'b0;
  endtask

  task automatic start_move(input int steps);
    move_start = 1'b1;
    move_steps = POS_W'(steps);
    tick();
    move_start = 1'b0;
  endtask

  task automatic clear_pos();
    pos_clr = 1'b1;
    tick();
    pos_clr = 1'b0;
  endtask

  // Index j holds the outputs seen in the j-th cycle after the start strobe.
  task automatic capture(input int n);
    cap_step[0] = 1'b0;
    for (int j = 1; j <= n; j++) begin
      cap_step[j]  = drv_step;
      cap_done[j]  = done;
      cap_busy[j]  = busy;
      cap_abort[j] = aborted;
      cap_dir[j]   = drv_dir;
      tick();
    end
  endtask

  task automatic analyze(input int n);
    num_p = 0; done_cyc = 0; done_cnt = 0; abort_cyc = 0; abort_cnt = 0; busy_last = 0;
    for (int k = 0; k < 8; k++) begin rise[k] = 0; hlen[k] = 0; end
    for (int j = 1; j <= n; j++) begin
      if (cap_step[j] && !cap_step[j-1] && num_p < 8) begin rise[num_p] = j; num_p++; end
      if (cap_step[j] && num_p > 0) hlen[num_p-1]++;
      if (cap_done[j]) begin if (done_cnt == 0) done_cyc = j; done_cnt++; end
      if (cap_abort[j]) begin if (abort_cnt == 0) abort_cyc = j; abort_cnt++; end
      if (cap_busy[j]) busy_last = j;
    end
  endtask

  task automatic test_reset();
    n_total++; if (drv_step !== 1'b0) $display("FAIL rst_step: got %0b expected 0", drv_step); else n_pass++;
    n_total++; if (drv_dir !== 1'b0) $display("FAIL rst_dir: got %0b expected 0", drv_dir); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b expected 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %0b expected 0", done); else n_pass++;
    n_total++; if (aborted !== 1'b0) $display("FAIL rst_aborted: got %0b expected 0", aborted); else n_pass++;
    n_total++; if (position !== 32'h0) $display("FAIL rst_position: got %0h expected 0", position); else n_pass++;
  endtask

  // Reset shadow: N=0, pw=1, dir=0 -> 1 high, 1 low, done at t+3.
  task automatic test_reset_shadow();
    start_move(1);
    capture(6); analyze(6);
    n_total++; if (num_p !== 1) $display("FAIL rsh_npulses: got %0d expected 1", num_p); else n_pass++;
    n_total++; if (rise[0] !== 1 || hlen[0] !== 1) $display("FAIL rsh_pulse: got rise %0d len %0d expected rise 1 len 1", rise[0], hlen[0]); else n_pass++;
    n_total++; if (done_cyc !== 3) $display("FAIL rsh_done: got %0d expected 3", done_cyc); else n_pass++;
    n_total++; if (position !== 32'hFFFF_FFFF) $display("FAIL rsh_position: got %0h expected ffffffff", position); else n_pass++;
    clear_pos();
    n_total++; if (position !== 32'h0) $display("FAIL rsh_posclr: got %0h expected 0", position); else n_pass++;
  endtask

  // drv_dir 0 -> 1: 4 setup cycles, high t+5..t+7, low 7, done t+15.
  task automatic test_dir_setup_pos();
    load_shadow(9, 3, 1'b1);
    start_move(1);
    capture(18); analyze(18);
    n_total++; if (cap_dir[1] !== 1'b1) $display("FAIL dsp_dir: got %0b expected 1", cap_dir[1]); else n_pass++;
    n_total++; if (rise[0] !== 5 || hlen[0] !== 3) $display("FAIL dsp_pulse: got rise %0d len %0d expected rise 5 len 3", rise[0], hlen[0]); else n_pass++;
    n_total++; if (done_cyc !== 15) $display("FAIL dsp_done: got %0d expected 15", done_cyc); else n_pass++;
    n_total++; if (position !== 32'h1) $display("FAIL dsp_position: got %0h expected 1", position); else n_pass++;
    clear_pos();
  endtask

  task automatic test_basic();
    load_shadow(9, 3, 1'b1);
    start_move(2);
    capture(24); analyze(24);
    n_total++; if (num_p !== 2) $display("FAIL basic_npulses: got %0d expected 2", num_p); else n_pass++;
    n_total++; if (rise[0] !== 1 || rise[1] !== 11) $display("FAIL basic_rise: got %0d,%0d expected 1,11", rise[0], rise[1]); else n_pass++;
    n_total++; if (hlen[0] !== 3 || hlen[1] !== 3) $display("FAIL basic_hlen: got %0d,%0d expected 3,3", hlen[0], hlen[1]); else n_pass++;
    n_total++; if (done_cyc !== 21 || done_cnt !== 1) $display("FAIL basic_done: got cyc %0d cnt %0d expected cyc 21 cnt 1", done_cyc, done_cnt); else n_pass++;
    n_total++; if (busy_last !== 20 || cap_busy[1] !== 1'b1) $display("FAIL basic_busy: got last %0d first %0b expected last 20 first 1", busy_last, cap_busy[1]); else n_pass++;
    n_total++; if (position !== 32'h2) $display("FAIL basic_position: got %0h expected 2", position); else n_pass++;
  endtask

  task automatic test_dir_change();
    clear_pos();
    load_shadow(9, 3, 1'b0);
    n_total++; if (drv_dir !== 1'b1) $display("FAIL dch_dir_before: got %0b expected 1", drv_dir); else n_pass++;
    start_move(1);
    capture(18); analyze(18);
    n_total++; if (cap_dir[1] !== 1'b0) $display("FAIL dch_dir_after: got %0b expected 0", cap_dir[1]); else n_pass++;
    n_total++; if (rise[0] !== 5 || hlen[0] !== 3) $display("FAIL dch_pulse: got rise %0d len %0d expected rise 5 len 3", rise[0], hlen[0]); else n_pass++;
    n_total++; if (position !== 32'hFFFF_FFFF) $display("FAIL dch_position: got %0h expected ffffffff", position); else n_pass++;
  endtask

  // N=2, pw=5: N+1 <= pw so low is 1 clock, period 6.
  task automatic test_wide_pulse();
    load_shadow(2, 5, 1'b0);
    start_move(3);
    capture(22); analyze(22);
    n_total++; if (rise[0] !== 1 || rise[1] !== 7 || rise[2] !== 13) $display("FAIL wide_rise: got %0d,%0d,%0d expected 1,7,13", rise[0], rise[1], rise[2]); else n_pass++;
    n_total++; if (hlen[0] !== 5 || hlen[1] !== 5 || hlen[2] !== 5) $display("FAIL wide_hlen: got %0d,%0d,%0d expected 5,5,5", hlen[0], hlen[1], hlen[2]); else n_pass++;
    n_total++; if (done_cyc !== 19 || busy_last !== 18) $display("FAIL wide_done: got done %0d busy_last %0d expected 19,18", done_cyc, busy_last); else n_pass++;
    n_total++; if (position !== 32'hFFFF_FFFC) $display("FAIL wide_position: got %0h expected fffffffc", position); else n_pass++;
  endtask

  // pw=0 behaves as 1: N=3 -> 1 high + 3 low.
  task automatic test_pw_zero();
    load_shadow(3, 0, 1'b0);
    start_move(2);
    capture(12); analyze(12);
    n_total++; if (rise[0] !== 1 || rise[1] !== 5) $display("FAIL pw0_rise: got %0d,%0d expected 1,5", rise[0], rise[1]); else n_pass++;
    n_total++; if (hlen[0] !== 1 || hlen[1] !== 1) $display("FAIL pw0_hlen: got %0d,%0d expected 1,1", hlen[0], hlen[1]); else n_pass++;
    n_total++; if (done_cyc !== 9) $display("FAIL pw0_done: got %0d expected 9", done_cyc); else n_pass++;
    n_total++; if (position !== 32'hFFFF_FFFA) $display("FAIL pw0_position: got %0h expected fffffffa", position); else n_pass++;
  endtask

  // New N=19 latched during step 1 applies from step 2 on.
  task automatic test_midmove_trig();
    load_shadow(9, 3, 1'b0);
    start_move(3);
    fork
      capture(54);
      begin
        tick();
        n_val = PER_W'(19); pw_val = PW_W'(3); dir_in = 1'b0; trig = 1'b1;
        tick();
        trig = 1'b0;
      end
    join
    analyze(54);
    n_total++; if (num_p !== 3) $display("FAIL mid_npulses: got %0d expected 3", num_p); else n_pass++;
    n_total++; if (rise[0] !== 1 || rise[1] !== 11 || rise[2] !== 31) $display("FAIL mid_rise: got %0d,%0d,%0d expected 1,11,31", rise[0], rise[1], rise[2]); else n_pass++;
    n_total++; if (hlen[0] !== 3 || hlen[1] !== 3 || hlen[2] !== 3) $display("FAIL mid_hlen: got %0d,%0d,%0d expected 3,3,3", hlen[0], hlen[1], hlen[2]); else n_pass++;
    n_total++; if (done_cyc !== 51) $display("FAIL mid_done: got %0d expected 51", done_cyc); else n_pass++;
    n_total++; if (position !== 32'hFFFF_FFF7) $display("FAIL mid_position: got %0h expected fffffff7", position); else n_pass++;
  endtask

  // Enable drops in the first HIGH cycle of step 2; a move_start in LOW is ignored.
  task automatic test_abort_high();
    clear_pos();
    load_shadow(9, 3, 1'b1);
    start_move(5);
    fork
      capture(24);
      begin
        repeat (9) tick();
        move_start = 1'b1; move_steps = POS_W'(7);
        tick();
        move_start = 1'b0;
        repeat (4) tick();
        en = 1'b0;
      end
    join
    analyze(24);
    en = 1'b1;
    n_total++; if (num_p !== 2) $display("FAIL abh_npulses: got %0d expected 2", num_p); else n_pass++;
    n_total++; if (rise[0] !== 5 || rise[1] !== 15) $display("FAIL abh_rise: got %0d,%0d expected 5,15", rise[0], rise[1]); else n_pass++;
    n_total++; if (hlen[1] !== 3) $display("FAIL abh_hlen: got %0d expected 3", hlen[1]); else n_pass++;
    n_total++; if (abort_cyc !== 18 || abort_cnt !== 1) $display("FAIL abh_aborted: got cyc %0d cnt %0d expected cyc 18 cnt 1", abort_cyc, abort_cnt); else n_pass++;
    n_total++; if (done_cnt !== 0) $display("FAIL abh_done: got %0d expected 0", done_cnt); else n_pass++;
    n_total++; if (busy_last !== 17) $display("FAIL abh_busy: got %0d expected 17", busy_last); else n_pass++;
    n_total++; if (position !== 32'h2) $display("FAIL abh_position: got %0h expected 2", position); else n_pass++;
  endtask

  task automatic test_abort_low();
    load_shadow(9, 3, 1'b1);
    start_move(3);
    fork
      capture(12);
      begin
        repeat (5) tick();
        en = 1'b0;
      end
    join
    analyze(12);
    en = 1'b1;
    n_total++; if (abort_cyc !== 7 || busy_last !== 6) $display("FAIL abl_aborted: got cyc %0d busy_last %0d expected 7,6", abort_cyc, busy_last); else n_pass++;
    n_total++; if (num_p !== 1 || done_cnt !== 0) $display("FAIL abl_pulses: got %0d pulses %0d done expected 1,0", num_p, done_cnt); else n_pass++;
    n_total++; if (position !== 32'h3) $display("FAIL abl_position: got %0h expected 3", position); else n_pass++;
  endtask

  task automatic test_zero_steps();
    start_move(0);
    capture(4); analyze(4);
    n_total++; if (done_cyc !== 1 || done_cnt !== 1) $display("FAIL zero_done: got cyc %0d cnt %0d expected 1,1", done_cyc, done_cnt); else n_pass++;
    n_total++; if (num_p !== 0 || busy_last !== 0) $display("FAIL zero_idle: got %0d pulses busy_last %0d expected 0,0", num_p, busy_last); else n_pass++;
    en = 1'b0;
    start_move(2);
    capture(6); analyze(6);
    en = 1'b1;
    n_total++; if (num_p !== 0 || busy_last !== 0 || done_cnt !== 0) $display("FAIL dis_start: got %0d pulses busy_last %0d done %0d expected 0,0,0", num_p, busy_last, done_cnt); else n_pass++;
    n_total++; if (position !== 32'h3) $display("FAIL zero_position: got %0h expected 3", position); else n_pass++;
  endtask

  // pos_clr in the last HIGH cycle wins over the +1 update.
  task automatic test_pos_clr_priority();
    load_shadow(9, 3, 1'b1);
    start_move(1);
    fork
      capture(12);
      begin
        repeat (2) tick();
        pos_clr = 1'b1;
        tick();
        pos_clr = 1'b0;
      end
    join
    analyze(12);
    n_total++; if (position !== 32'h0) $display("FAIL pclr_position: got %0h expected 0", position); else n_pass++;
    n_total++; if (done_cyc !== 11) $display("FAIL pclr_done: got %0d expected 11", done_cyc); else n_pass++;
  endtask

  task automatic test_rst_mid_high();
    load_shadow(9, 3, 1'b1);
    start_move(2);
    n_total++; if (drv_step !== 1'b1) $display("FAIL rmh_step_before: got %0b expected 1", drv_step); else n_pass++;
    tick();
    rst = 1'b1;
    tick();
    n_total++; if (drv_step !== 1'b0 || busy !== 1'b0) $display("FAIL rmh_step_after: got step %0b busy %0b expected 0,0", drv_step, busy); else n_pass++;
    n_total++; if (done !== 1'b0 || aborted !== 1'b0) $display("FAIL rmh_pulses: got done %0b aborted %0b expected 0,0", done, aborted); else n_pass++;
    rst = 1'b0;
    tick();
    n_total++; if (done !== 1'b0 || aborted !== 1'b0 || drv_dir !== 1'b0 || position !== 32'h0) $display("FAIL rmh_post: got done %0b aborted %0b dir %0b pos %0h expected 0,0,0,0", done, aborted, drv_dir, position); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; trig = 1'b0; n_val = '0; pw_val = '0; dir_in = 1'b0; en = 1'b1;
    move_start = 1'b0; move_steps = '0; pos_clr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_reset_shadow();
    test_dir_setup_pos();
    test_basic();
    test_dir_change();
    test_wide_pulse();
    test_pw_zero();
    test_midmove_trig();
    test_abort_high();
    test_abort_low();
    test_zero_steps();
    test_pos_clr_priority();
    test_rst_mid_high();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
